// File: rtl/axi_route_pkg.sv
// Shared target encoding and address decode for the LSU two-target AXI interconnect.
package axi_route_pkg;

   typedef enum logic {
      TGT_MEM    = 1'b0,
      TGT_BRIDGE = 1'b1
   } tgt_e;

   localparam logic [31:0] DEF_BRIDGE_BASE  = 32'h2000_0000;
   localparam logic [31:0] DEF_BRIDGE_LIMIT = 32'h8000_0000;

   // Both bounds are inclusive.
   function automatic tgt_e decode_tgt(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
      return ((addr >= base) && (addr <= limit)) ? TGT_BRIDGE : TGT_MEM;
   endfunction

endpackage

// File: rtl/axi_route_track.sv
// One-direction tracker: decodes the request address, holds the in-flight target and count.
// Zero-latency allow/sel; a request to another target is held until the count drains to 0.
module axi_route_track
   import axi_route_pkg::*;
#(
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          CNT_W           = 3,
   parameter logic [31:0] BRIDGE_BASE     = DEF_BRIDGE_BASE,
   parameter logic [31:0] BRIDGE_LIMIT    = DEF_BRIDGE_LIMIT
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        req_valid,
   input  logic [31:0] addr,
   input  logic        req_ready,
   input  logic        rsp_done,
   output logic        sel,
   output logic        allow,
   output logic        cur_tgt,
   output logic        busy,
   output logic        accept,
   output logic        underflow
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

   tgt_e             addr_tgt;
   tgt_e             tgt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             idle;
   logic             dec;

   assign addr_tgt  = decode_tgt(addr, BRIDGE_BASE, BRIDGE_LIMIT);
   assign idle      = (cnt == '0);
   assign sel       = idle ? addr_tgt : tgt;
   assign allow     = idle | ((addr_tgt == tgt) & (cnt < MAX_CNT));
   assign accept    = req_valid & allow & req_ready;
   // A response with nothing outstanding is dropped from the count and reported.
   assign underflow = rsp_done & idle;
   assign dec       = rsp_done & ~idle;
   assign cur_tgt   = tgt;
   assign busy      = ~idle;

   always_comb begin
      cnt_nxt = cnt;
      if (accept && !dec) begin
         cnt_nxt = cnt + 1'b1;
      end else if (!accept && dec) begin
         cnt_nxt = cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         tgt <= TGT_MEM;
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
         if (accept) begin
            tgt <= addr_tgt;
         end
      end
   end

endmodule

// File: rtl/axi_route_ctrl.sv
// Routing controller for the LSU AXI memory/bridge interconnect: mux selects and valid/ready gates.
// Gates are combinational (zero latency); response selects follow the registered per-direction target.
module axi_route_ctrl
   import axi_route_pkg::*;
#(
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          CNT_W           = 3,
   parameter logic [31:0] BRIDGE_BASE     = DEF_BRIDGE_BASE,
   parameter logic [31:0] BRIDGE_LIMIT    = DEF_BRIDGE_LIMIT
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        lsu_axi_arvalid,
   input  logic [31:0] lsu_axi_araddr,
   input  logic        lsu_axi_arready,
   input  logic        lsu_axi_rvalid,
   input  logic        lsu_axi_rready,
   input  logic        lsu_axi_rlast,
   input  logic        lsu_axi_awvalid,
   input  logic [31:0] lsu_axi_awaddr,
   input  logic        lsu_axi_awready,
   input  logic        lsu_axi_wvalid,
   input  logic        lsu_axi_wready,
   input  logic        lsu_axi_wlast,
   input  logic        lsu_axi_bvalid,
   input  logic        lsu_axi_bready,
   output logic        ar_sel,
   output logic        ar_allow,
   output logic        r_sel,
   output logic        aw_sel,
   output logic        aw_allow,
   output logic        w_sel,
   output logic        w_allow,
   output logic        b_sel,
   output logic        rd_busy,
   output logic        wr_busy,
   output logic        protocol_err
);

   logic             r_done;
   logic             b_done;
   logic             w_done;
   logic             rd_accept;
   logic             aw_accept;
   logic             rd_under;
   logic             b_under;
   logic             wr_tgt;
   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             err;

   assign r_done = lsu_axi_rvalid & lsu_axi_rready & lsu_axi_rlast;
   assign b_done = lsu_axi_bvalid & lsu_axi_bready;

   axi_route_track #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W),
      .BRIDGE_BASE     (BRIDGE_BASE),
      .BRIDGE_LIMIT    (BRIDGE_LIMIT)
   ) u_rd (
      .clk       (clk),
      .rst_l     (rst_l),
      .req_valid (lsu_axi_arvalid),
      .addr      (lsu_axi_araddr),
      .req_ready (lsu_axi_arready),
      .rsp_done  (r_done),
      .sel       (ar_sel),
      .allow     (ar_allow),
      .cur_tgt   (r_sel),
      .busy      (rd_busy),
      .accept    (rd_accept),
      .underflow (rd_under)
   );

   // The AW tracker counts until B, so it also bounds W since B cannot precede its burst.
   axi_route_track #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W),
      .BRIDGE_BASE     (BRIDGE_BASE),
      .BRIDGE_LIMIT    (BRIDGE_LIMIT)
   ) u_wr (
      .clk       (clk),
      .rst_l     (rst_l),
      .req_valid (lsu_axi_awvalid),
      .addr      (lsu_axi_awaddr),
      .req_ready (lsu_axi_awready),
      .rsp_done  (b_done),
      .sel       (aw_sel),
      .allow     (aw_allow),
      .cur_tgt   (wr_tgt),
      .busy      (wr_busy),
      .accept    (aw_accept),
      .underflow (b_under)
   );

   // W is held off until its AW has been accepted, so w_cnt cannot underflow.
   assign w_allow = (w_cnt != '0);
   assign w_done  = lsu_axi_wvalid & w_allow & lsu_axi_wready & lsu_axi_wlast;
   assign w_sel   = wr_tgt;
   assign b_sel   = wr_tgt;

   always_comb begin
      w_cnt_nxt = w_cnt;
      if (aw_accept && !w_done) begin
         w_cnt_nxt = w_cnt + 1'b1;
      end else if (!aw_accept && w_done) begin
         w_cnt_nxt = w_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         w_cnt <= '0;
         err   <= 1'b0;
      end else begin
         w_cnt <= w_cnt_nxt;
         err   <= err | rd_under | b_under;
      end
   end

   assign protocol_err = err;

endmodule

// File: tb/tb_axi_route_ctrl.sv
// Directed vector bench for axi_route_ctrl: table of per-cycle inputs and expected outputs.
module tb_axi_route_ctrl;

   logic        clk;
   logic        rst_l;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] araddr, awaddr;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic        ar_sel, ar_allow, r_sel, aw_sel, aw_allow, w_sel, w_allow, b_sel;
   logic        rd_busy, wr_busy, protocol_err;
   logic [10:0] obs;

   int checks;
   int errors;

   localparam logic [31:0] A0 = 32'h8000_1000;
   localparam logic [31:0] AB = 32'h2000_0000;
   localparam logic [31:0] A9 = 32'h9000_0000;
   localparam logic [31:0] A4 = 32'h4000_0000;

   // Expected bit order: ar_sel ar_allow r_sel aw_sel aw_allow w_sel w_allow b_sel rd_busy wr_busy err
   localparam logic [10:0] E_IDLE = 11'b01001000000;
   localparam logic [10:0] E_RD   = 11'b01001000100;
   localparam logic [10:0] E_FULL = 11'b00001000100;

   typedef struct {
      logic        arv;
      logic [31:0] ara;
      logic        arr;
      logic        rv;
      logic        rr;
      logic        rl;
      logic        awv;
      logic [31:0] awa;
      logic        awr;
      logic        wv;
      logic        wr;
      logic        wl;
      logic        bv;
      logic        br;
      logic [10:0] exp;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vecs[33];

   axi_route_ctrl u_dut (
      .clk             (clk),
      .rst_l           (rst_l),
      .lsu_axi_arvalid (arvalid),
      .lsu_axi_araddr  (araddr),
      .lsu_axi_arready (arready),
      .lsu_axi_rvalid  (rvalid),
      .lsu_axi_rready  (rready),
      .lsu_axi_rlast   (rlast),
      .lsu_axi_awvalid (awvalid),
      .lsu_axi_awaddr  (awaddr),
      .lsu_axi_awready (awready),
      .lsu_axi_wvalid  (wvalid),
      .lsu_axi_wready  (wready),
      .lsu_axi_wlast   (wlast),
      .lsu_axi_bvalid  (bvalid),
      .lsu_axi_bready  (bready),
      .ar_sel          (ar_sel),
      .ar_allow        (ar_allow),
      .r_sel           (r_sel),
      .aw_sel          (aw_sel),
      .aw_allow        (aw_allow),
      .w_sel           (w_sel),
      .w_allow         (w_allow),
      .b_sel           (b_sel),
      .rd_busy         (rd_busy),
      .wr_busy         (wr_busy),
      .protocol_err    (protocol_err)
   );

   assign obs = {ar_sel, ar_allow, r_sel, aw_sel, aw_allow, w_sel, w_allow, b_sel,
                 rd_busy, wr_busy, protocol_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply(input vec_t v);
      arvalid = v.arv; araddr = v.ara; arready = v.arr;
      rvalid  = v.rv;  rready = v.rr;  rlast   = v.rl;
      awvalid = v.awv; awaddr = v.awa; awready = v.awr;
      wvalid  = v.wv;  wready = v.wr;  wlast   = v.wl;
      bvalid  = v.bv;  bready = v.br;
   endtask

   task automatic idle_inputs();
      arvalid = 0; araddr = '0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
      awvalid = 0; awaddr = '0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
      bvalid = 0; bready = 0;
   endtask

   task automatic check_out(input string name, input int idx, input logic [10:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: outputs got %b want %b", name, idx, obs, exp);
      end
   endtask

   task automatic check_cnt(input string name, input int idx, input logic [2:0] exp);
      checks++;
      if (u_dut.u_rd.cnt !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: rd_cnt got %0d want %0d", name, idx, u_dut.u_rd.cnt, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      //           arv ara arr rv rr rl awv awa awr wv wr wl bv br exp cnt
      // Two back-to-back memory reads, single-beat responses.
      vecs[0]  = '{0, A0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_IDLE, 3'd0};
      vecs[1]  = '{1, A0, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_IDLE, 3'd0};
      vecs[2]  = '{1, A0, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd1};
      vecs[3]  = '{0, A0, 0, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd2};
      vecs[4]  = '{0, A0, 0, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd1};
      vecs[5]  = '{0, A0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_IDLE, 3'd0};
      // Bridge read outstanding, memory AR stalled until the R-last handshake.
      vecs[6]  = '{1, AB, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 11'b11001000000, 3'd0};
      vecs[7]  = '{1, A9, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 11'b10101000100, 3'd1};
      vecs[8]  = '{1, A9, 1, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, 11'b10101000100, 3'd1};
      vecs[9]  = '{1, A9, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 11'b01101000000, 3'd0};
      vecs[10] = '{0, A9, 0, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd1};
      // Five same-target ARs with no responses: the fifth waits for one R-last.
      vecs[11] = '{1, A0, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_IDLE, 3'd0};
      vecs[12] = '{1, A0, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd1};
      vecs[13] = '{1, A0, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd2};
      vecs[14] = '{1, A0, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd3};
      vecs[15] = '{1, A0, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_FULL, 3'd4};
      vecs[16] = '{1, A0, 1, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, E_FULL, 3'd4};
      vecs[17] = '{1, A0, 1, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd3};
      // Drain to 2, then accept and complete in the same cycle.
      vecs[18] = '{0, A0, 0, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, E_FULL, 3'd4};
      vecs[19] = '{0, A0, 0, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd3};
      vecs[20] = '{1, A0, 1, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd2};
      vecs[21] = '{0, A0, 0, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd2};
      vecs[22] = '{0, A0, 0, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, E_RD,   3'd1};
      vecs[23] = '{0, A0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, E_IDLE, 3'd0};
      // W before AW to the bridge, then B.
      vecs[24] = '{0, A0, 0, 0, 0, 0, 0, A4, 0, 1, 1, 1, 0, 0, 11'b01011000000, 3'd0};
      vecs[25] = '{0, A0, 0, 0, 0, 0, 1, A4, 1, 1, 1, 1, 0, 0, 11'b01011000000, 3'd0};
      vecs[26] = '{0, A0, 0, 0, 0, 0, 0, A4, 0, 1, 1, 1, 0, 0, 11'b01011111010, 3'd0};
      vecs[27] = '{0, A0, 0, 0, 0, 0, 0, A4, 0, 0, 0, 0, 0, 0, 11'b01011101010, 3'd0};
      vecs[28] = '{0, A0, 0, 0, 0, 0, 0, A4, 0, 0, 0, 0, 1, 1, 11'b01011101010, 3'd0};
      vecs[29] = '{0, A0, 0, 0, 0, 0, 0, A4, 0, 0, 0, 0, 0, 0, 11'b01011101000, 3'd0};
      // Spurious B with nothing outstanding sets the sticky error.
      vecs[30] = '{0, A0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 1, 1, 11'b01001101000, 3'd0};
      vecs[31] = '{0, A0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 11'b01001101001, 3'd0};
      vecs[32] = '{0, A0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0, 0, 0, 11'b01001101001, 3'd0};

      idle_inputs();
      rst_l = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_out("in_reset", 0, E_IDLE);
      @(negedge clk);
      rst_l = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         check_out("vec", i, vecs[i].exp);
         check_cnt("vec", i, vecs[i].cnt);
      end

      // Asynchronous reset clears the sticky error and the write target.
      @(negedge clk);
      idle_inputs();
      rst_l = 1'b0;
      #1;
      check_out("rst_clear", 0, E_IDLE);
      check_cnt("rst_clear", 0, 3'd0);

      // Reset with a read in flight, then its late response flags an error.
      @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      arvalid = 1; araddr = A0; arready = 1;
      @(negedge clk);
      idle_inputs();
      #1;
      check_out("inflight", 0, E_RD);
      rst_l = 1'b0;
      #1;
      check_out("inflight_rst", 0, E_IDLE);
      @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      rvalid = 1; rready = 1; rlast = 1;
      #1;
      check_out("late_rsp", 0, E_IDLE);
      @(negedge clk);
      idle_inputs();
      #1;
      check_out("late_rsp_err", 0, 11'b01001000001);
      check_cnt("late_rsp_err", 0, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_route_ctrl.md
Name: axi_route_ctrl

Overview:
- Sequencing controller for the LSU AXI two-target interconnect (external memory = target 0, bridge = target 1).
- Decodes each AR/AW address and latches the routing decision per transaction, so R/W/B traffic follows the request that caused it.
- Tracks outstanding reads and writes, and stalls a request to a different target until the current target drains.
- Drives the select and gate signals for the interconnect muxes; carries no AXI data itself.

Parameters:
- MAX_OUTSTANDING, 4: max in-flight transactions per direction (reads; writes). Must be 1..7.
- CNT_W, 3: counter width; must satisfy 2^CNT_W > MAX_OUTSTANDING.
- BRIDGE_BASE, 32'h2000_0000: lowest bridge address, inclusive.
- BRIDGE_LIMIT, 32'h8000_0000: highest bridge address, inclusive.

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- lsu_axi_arvalid  in  1  master AR valid
- lsu_axi_araddr  in  32  master AR address
- lsu_axi_arready  in  1  AR ready from the selected target (post-mux)
- lsu_axi_rvalid  in  1  R valid from the selected target
- lsu_axi_rready  in  1  master R ready
- lsu_axi_rlast  in  1  R last
- lsu_axi_awvalid  in  1  master AW valid
- lsu_axi_awaddr  in  32  master AW address
- lsu_axi_awready  in  1  AW ready from the selected target
- lsu_axi_wvalid  in  1  master W valid
- lsu_axi_wready  in  1  W ready from the selected target
- lsu_axi_wlast  in  1  W last
- lsu_axi_bvalid  in  1  B valid from the selected target
- lsu_axi_bready  in  1  master B ready
- ar_sel  out  1  AR request mux select (1 = bridge)
- ar_allow  out  1  gate: AR valid/ready pass only when 1
- r_sel  out  1  R response mux select
- aw_sel  out  1  AW request mux select
- aw_allow  out  1  AW gate
- w_sel  out  1  W mux select
- w_allow  out  1  W gate
- b_sel  out  1  B response mux select
- rd_busy  out  1  rd_cnt != 0
- wr_busy  out  1  b_cnt != 0
- protocol_err  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_l is asynchronous and active-low. All state is cleared asynchronously on assertion and released synchronously to clk.
- Decode: tgt(a) = 1 when BRIDGE_BASE <= a <= BRIDGE_LIMIT, else 0.

Read path:
- Registers: rd_tgt (reset 0) and rd_cnt (reset 0).
- ar_sel = (rd_cnt == 0) ? tgt(araddr) : rd_tgt.
- ar_allow = (rd_cnt == 0) | ((tgt(araddr) == rd_tgt) & (rd_cnt < MAX_OUTSTANDING)). Purely combinational, zero latency.
- AR accept = arvalid & ar_allow & arready. On accept: rd_tgt <= tgt(araddr).
- R done = rvalid & rready & rlast.
- rd_cnt next = rd_cnt + accept - done. Accept and done in the same cycle leave it unchanged.
- r_sel = rd_tgt (registered).

Write path:
- Registers: wr_tgt (reset 0), b_cnt (AW accepted minus B handshakes, reset 0), w_cnt (AW accepted minus W bursts completed, reset 0).
- aw_sel and aw_allow follow the read-path rules, using awaddr, wr_tgt and b_cnt.
- AW accept = awvalid & aw_allow & awready.
- w_allow = (w_cnt != 0). W data arriving before its AW is held off.
- W done = wvalid & w_allow & wready & wlast.
- B done = bvalid & bready.
- w_sel = b_sel = wr_tgt. All writes in flight share one target, so a single register suffices.
- On AW accept: wr_tgt <= tgt(awaddr).
- Counter updates: w_cnt += AW accept - W done; b_cnt += AW accept - B done.
- The AW accept and the matching W burst may complete in the same cycle only if w_cnt was already nonzero.

Boundary conditions:
- Full: at count == MAX_OUTSTANDING, allow = 0 even for the same target.
- Target switch: allowed only once the count reaches 0. The cycle after the last response, the new target is selected with no bubble beyond that cycle.
- Decrement event while the relevant count is 0 (R done, W done or B done): counter holds at 0 and protocol_err <= 1.
- protocol_err is cleared only by reset.
- Reset mid-transaction: all counts go to 0, selects go to 0 and allows are recomputed. Any in-flight downstream response after reset flags protocol_err.

Decomposition:
- Shared package axi_route_pkg: typedef enum logic {TGT_MEM = 0, TGT_BRIDGE = 1} tgt_e, plus BRIDGE_BASE/BRIDGE_LIMIT defaults. The interconnect and this block import both.
- One sub-module, axi_route_track: a single-direction tracker (decode, target register, up/down counter, allow logic, underflow detect).
  - Instantiated once for the read path and once for the AW/B path.
  - w_cnt lives in the top level.

Test Plan:
- Two reads to 0x8000_1000 back-to-back, each with a single-beat R → ar_sel = 0, ar_allow = 1 for both, rd_cnt goes 1→2→1→0, r_sel = 0 throughout.
- Read to 0x2000_0000 outstanding, then AR to 0x9000_0000 → ar_allow = 0 until the rlast handshake; the next cycle ar_sel = 0, ar_allow = 1, and the AR is accepted.
- Five same-target ARs with no R (MAX_OUTSTANDING = 4) → four accepted, the fifth is stalled until one R-last completes.
- W valid before AW (addr 0x4000_0000) → w_allow = 0 until AW is accepted; then w_allow = 1, w_sel = 1, the wlast beat completes, and b_cnt = 1 until B, then wr_busy = 0.
- AR accept and R-last done in the same cycle with rd_cnt = 2 → rd_cnt stays 2.
- Spurious bvalid & bready with b_cnt = 0 → protocol_err = 1 and stays set; rst_l low clears it and all outputs return to 0 except ar_allow and aw_allow (= 1).
